// File: rtl/mostrador_sequencia.sv
// mostrador_sequencia: plays ROM entries 0..rodada on the LEDs,
// each lit for T_ON cycles then blanked for T_OFF cycles.
module mostrador_sequencia #(
  parameter int T_ON  = 1000,
  parameter int T_OFF = 500
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       iniciar,
  input  logic       cancela,
  input  logic [3:0] rodada,
  output logic [3:0] endereco,
  input  logic [3:0] dado,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       pronto,
  output logic [2:0] db_estado
);

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    ENDERECA = 3'd1,
    CARREGA  = 3'd2,
    ACESO    = 3'd3,
    APAGADO  = 3'd4,
    FIM      = 3'd5
  } estado_t;

  localparam logic [15:0] ON_FIM  = 16'(T_ON - 1);
  localparam logic [15:0] OFF_FIM = 16'(T_OFF - 1);

  estado_t     estado;
  logic [15:0] timer;
  logic [3:0]  rodada_q;
  logic [3:0]  dado_q;

  // Sequencer: state, address, dwell timer and status flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado   <= OCIOSO;
      endereco <= '0;
      timer    <= '0;
      rodada_q <= '0;
      dado_q   <= '0;
      ocupado  <= 1'b0;
      pronto   <= 1'b0;
    end else begin
      pronto <= 1'b0;
      if (cancela && estado != OCIOSO) begin
        estado  <= OCIOSO;
        timer   <= '0;
        ocupado <= 1'b0;
      end else begin
        case (estado)
          OCIOSO: begin
            if (iniciar && !cancela) begin
              rodada_q <= rodada;
              endereco <= '0;
              timer    <= '0;
              ocupado  <= 1'b1;
              estado   <= ENDERECA;
            end
          end
          ENDERECA: begin
            estado <= CARREGA;
          end
          CARREGA: begin
            dado_q <= dado;
            timer  <= '0;
            estado <= ACESO;
          end
          ACESO: begin
            if (timer == ON_FIM) begin
              timer  <= '0;
              estado <= APAGADO;
            end else begin
              timer <= timer + 16'd1;
            end
          end
          APAGADO: begin
            if (timer == OFF_FIM) begin
              timer <= '0;
              if (endereco == rodada_q) begin
                pronto <= 1'b1;
                estado <= FIM;
              end else begin
                endereco <= endereco + 4'd1;
                estado   <= ENDERECA;
              end
            end else begin
              timer <= timer + 16'd1;
            end
          end
          FIM: begin
            ocupado <= 1'b0;
            estado  <= OCIOSO;
          end
          default: begin
            timer   <= '0;
            ocupado <= 1'b0;
            estado  <= OCIOSO;
          end
        endcase
      end
    end
  end

  // LEDs lit only while the entry is being shown
  always_comb begin
    leds = '0;
    if (estado == ACESO) leds = dado_q;
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_mostrador_sequencia.sv
// tb_mostrador_sequencia: directed vectors and playback sequences
// against a synchronous 16x4 ROM model.
module tb_mostrador_sequencia;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       iniciar;
  logic       cancela;
  logic [3:0] rodada;
  logic [3:0] endereco;
  logic [3:0] dado;
  logic [3:0] leds;
  logic       ocupado;
  logic       pronto;
  logic [2:0] db_estado;

  logic [3:0] rom [16];

  int errors = 0;
  int checks = 0;

  mostrador_sequencia #(.T_ON(3), .T_OFF(2)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .iniciar   (iniciar),
    .cancela   (cancela),
    .rodada    (rodada),
    .endereco  (endereco),
    .dado      (dado),
    .leds      (leds),
    .ocupado   (ocupado),
    .pronto    (pronto),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  always_ff @(posedge clock) dado <= rom[endereco];

  typedef struct {
    logic       ini;
    logic       can;
    logic [3:0] rod;
    logic [3:0] leds;
    logic       ocup;
    logic       pr;
    logic [2:0] est;
    logic [3:0] ende;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " estado"}, int'(db_estado), 0);
    chk({tag, " leds"}, int'(leds), 0);
    chk({tag, " ocupado"}, int'(ocupado), 0);
    chk({tag, " pronto"}, int'(pronto), 0);
  endtask

  // Plays entries 0..last; optional disturbances or abort at cycle abort_at
  task automatic play(input int last, input bit disturb, input int abort_at);
    int n;
    int e;
    int p;
    int x_est;
    int x_leds;
    string t;
    n = (last + 1) * 7;
    rodada  = 4'(last);
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    for (int k = 0; k <= n; k++) begin
      e = (k < n) ? k / 7 : last;
      p = k % 7;
      if (k == n) x_est = 5;
      else if (p == 0) x_est = 1;
      else if (p == 1) x_est = 2;
      else if (p < 5) x_est = 3;
      else x_est = 4;
      x_leds = (k < n && p >= 2 && p < 5) ? int'(rom[e]) : 0;
      t = $sformatf("play%0d k%0d", last, k);
      chk({t, " estado"}, int'(db_estado), x_est);
      chk({t, " leds"}, int'(leds), x_leds);
      chk({t, " endereco"}, int'(endereco), e);
      chk({t, " ocupado"}, int'(ocupado), 1);
      chk({t, " pronto"}, int'(pronto), (k == n) ? 1 : 0);
      if (k == abort_at) begin
        cancela = 1'b1;
        tick();
        cancela = 1'b0;
        chk_idle({t, " abort"});
        for (int j = 0; j < 10; j++) begin
          tick();
          chk_idle($sformatf("%s post-abort %0d", t, j));
        end
        return;
      end
      if (disturb) begin
        if (k == 4 || k == 12) iniciar = 1'b1;
        if (k == 5 || k == 13) iniciar = 1'b0;
        if (k == 10) rodada = 4'd0;
      end
      tick();
    end
    chk_idle($sformatf("play%0d end", last));
    chk($sformatf("play%0d end endereco", last), int'(endereco), last);
    tick();
    chk_idle($sformatf("play%0d after", last));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 4'd0;
    rom[0] = 4'b0001;
    rom[1] = 4'b0100;
    rom[2] = 4'b1000;

    tbl[0]  = '{1'b1, 1'b0, 4'd0, 4'b0000, 1'b1, 1'b0, 3'd1, 4'd0};
    tbl[1]  = '{1'b0, 1'b0, 4'd0, 4'b0000, 1'b1, 1'b0, 3'd2, 4'd0};
    tbl[2]  = '{1'b0, 1'b0, 4'd0, 4'b0001, 1'b1, 1'b0, 3'd3, 4'd0};
    tbl[3]  = '{1'b0, 1'b0, 4'd0, 4'b0001, 1'b1, 1'b0, 3'd3, 4'd0};
    tbl[4]  = '{1'b0, 1'b0, 4'd0, 4'b0001, 1'b1, 1'b0, 3'd3, 4'd0};
    tbl[5]  = '{1'b0, 1'b0, 4'd0, 4'b0000, 1'b1, 1'b0, 3'd4, 4'd0};
    tbl[6]  = '{1'b0, 1'b0, 4'd0, 4'b0000, 1'b1, 1'b0, 3'd4, 4'd0};
    tbl[7]  = '{1'b0, 1'b0, 4'd0, 4'b0000, 1'b1, 1'b1, 3'd5, 4'd0};
    tbl[8]  = '{1'b0, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'd0};
    tbl[9]  = '{1'b0, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'd0};
    tbl[10] = '{1'b1, 1'b1, 4'd3, 4'b0000, 1'b0, 1'b0, 3'd0, 4'd0};

    reset_n = 1'b0;
    iniciar = 1'b0;
    cancela = 1'b0;
    rodada  = 4'd0;
    #12;
    chk_idle("reset");
    chk("reset endereco", int'(endereco), 0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    chk_idle("post-reset idle");

    for (int i = 0; i < 11; i++) begin
      iniciar = tbl[i].ini;
      cancela = tbl[i].can;
      rodada  = tbl[i].rod;
      tick();
      chk($sformatf("vec%0d estado", i), int'(db_estado), int'(tbl[i].est));
      chk($sformatf("vec%0d leds", i), int'(leds), int'(tbl[i].leds));
      chk($sformatf("vec%0d ocupado", i), int'(ocupado), int'(tbl[i].ocup));
      chk($sformatf("vec%0d pronto", i), int'(pronto), int'(tbl[i].pr));
      chk($sformatf("vec%0d endereco", i), int'(endereco), int'(tbl[i].ende));
    end
    iniciar = 1'b0;
    cancela = 1'b0;
    tick();

    play(2, 1'b0, -1);
    play(2, 1'b0, 9);
    play(0, 1'b0, -1);
    play(2, 1'b1, -1);

    rodada  = 4'd2;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("rst-mid estado apagado", int'(db_estado), 4);
    #2;
    reset_n = 1'b0;
    #1;
    chk_idle("async reset");
    chk("async reset endereco", int'(endereco), 0);
    tick();
    chk_idle("reset held");
    @(negedge clock);
    reset_n = 1'b1;
    for (int j = 0; j < 12; j++) begin
      tick();
      chk_idle($sformatf("post-release %0d", j));
    end

    for (int i = 0; i < 16; i++) rom[i] = 4'(i);
    play(15, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
